seg7_scan_counter: RTL

Parametrised multi-digit BCD counter with a time-multiplexed seven-segment display driver. It is the next generation of our single-digit seven-segment user designs. It sits inside a `tt_um_*` top wrapper, which maps `seg`/`dp` onto `uo_out[7:0]` and `digit_sel` onto `uio_out` with `uio_oe` driven high. It adds:
- configurable digit count
- up/down counting with parallel load
- hold
- leading-zero blanking
- a wrap strobe

---
 rtl/seg7_scan_counter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_counter.sv
// Multi-digit BCD up/down counter with load, hold and wrap strobe,
// driving a time-multiplexed seven-segment display with zero blanking.
module seg7_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int SCAN_DIV = 64,
  parameter int DP_POS   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  up,
  input  logic                  hold,
  input  logic                  blank_lz,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int PW = $clog2(PRESCALE);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]       pcnt;
  logic [SW-1:0]       scnt;
  logic [IW-1:0]       idx;
  logic                step;
  logic [4*DIGITS-1:0] cnt_inc;
  logic [4*DIGITS-1:0] cnt_dec;
  logic [4*DIGITS-1:0] cnt_ld;
  logic                inc_c;
  logic                dec_b;
  logic [DIGITS-1:0]   zero_up;
  logic [3:0]          cur_dig;
  logic                blank;
  logic [6:0]          seg_dec;

  assign step = ena & ~hold & (pcnt == P_LAST);

  // Ripple carry/borrow; a carry out of the top digit is the wrap.
  always_comb begin
    cnt_inc = count;
    cnt_dec = count;
    cnt_ld  = '0;
    inc_c   = 1'b1;
    dec_b   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_c) begin
        if (count[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          inc_c = 1'b0;
        end
      end
      if (dec_b) begin
        if (count[4*i +: 4] == 4'd0) begin
          cnt_dec[4*i +: 4] = 4'd9;
        end else begin
          cnt_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          dec_b = 1'b0;
        end
      end
      cnt_ld[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ?
                         4'd9 : load_val[4*i +: 4];
    end
  end

  // zero_up[i]: digits i..DIGITS-1 are all zero.
  always_comb begin
    zero_up = '0;
    zero_up[DIGITS-1] = (count[4*DIGITS-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_up[i] = zero_up[i+1] & (count[4*i +: 4] == 4'd0);
    end
  end

  assign cur_dig = count[4*idx +: 4];
  assign blank   = blank_lz & (idx != '0) & zero_up[idx];

  always_comb begin
    case (cur_dig)
      4'd0:    seg_dec = 7'h3F;
      4'd1:    seg_dec = 7'h06;
      4'd2:    seg_dec = 7'h5B;
      4'd3:    seg_dec = 7'h4F;
      4'd4:    seg_dec = 7'h66;
      4'd5:    seg_dec = 7'h6D;
      4'd6:    seg_dec = 7'h7D;
      4'd7:    seg_dec = 7'h07;
      4'd8:    seg_dec = 7'h7F;
      4'd9:    seg_dec = 7'h6F;
      default: seg_dec = 7'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (ena) begin
      if (load) begin
        pcnt <= '0;
      end else if (!hold) begin
        pcnt <= step ? '0 : pcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (ena) begin
      wrap <= 1'b0;
      if (load) begin
        count <= cnt_ld;
      end else if (step && up) begin
        count <= cnt_inc;
        wrap  <= inc_c;
      end else if (step) begin
        count <= cnt_dec;
        wrap  <= dec_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
      idx  <= '0;
    end else if (ena) begin
      if (scnt == S_LAST) begin
        scnt <= '0;
        idx  <= (idx == I_LAST) ? '0 : idx + 1'b1;
      end else begin
        scnt <= scnt + 1'b1;
      end
    end
  end

  // Select, segments and point share one register stage: no ghosting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_sel <= '0;
      seg       <= '0;
      dp        <= 1'b0;
    end else if (ena) begin
      digit_sel <= DIGITS'(1) << idx;
      seg       <= blank ? 7'h00 : seg_dec;
      dp        <= (int'(idx) == DP_POS);
    end
  end

endmodule
